// File: rtl/ospi_flash_target_if.sv
// Octal-SPI target bus bundle: host-side strobes and data toward the flash model,
// plus the flash data return, output enable and busy mirror.
interface ospi_flash_target_if;
  logic       ospi_cs_n;
  logic       ospi_beat;
  logic [7:0] ospi_dq_in;
  logic [7:0] ospi_dq_out;
  logic       ospi_dq_oe;
  logic       busy;

  modport master (output ospi_cs_n, ospi_beat, ospi_dq_in,
                  input  ospi_dq_out, ospi_dq_oe, busy);
  modport slave  (input  ospi_cs_n, ospi_beat, ospi_dq_in,
                  output ospi_dq_out, ospi_dq_oe, busy);
endinterface

// File: rtl/ospi_flash_target.sv
// Octal-SPI (x8, SDR) flash target: command decode, read, page program, chip erase, status.
// Define OSPI_RDID_EN to enable the 0x9F read-ID command.
module ospi_flash_target #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DUMMY_CYCLES = 4,
  parameter int PAGE_SIZE    = 16,
  parameter int ERASE_CYCLES = 32
) (
  input logic                clk,
  input logic                reset_n,
  ospi_flash_target_if.slave bus
);
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int ECW        = $clog2(ERASE_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] PMASK = ADDR_WIDTH'(PAGE_SIZE - 1);

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h0B;
  localparam logic [7:0] OP_PROG  = 8'h02;
  localparam logic [7:0] OP_ERASE = 8'h60;
  localparam logic [7:0] OP_RDID  = 8'h9F;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DUMMY, S_RD, S_WR, S_STAT, S_IGNORE, S_ID
  } state_t;

  state_t                state, state_d;
  logic [7:0]            mem [DEPTH];
  logic [7:0]            cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] addr, addr_d, addr_inc, addr_pg;
  logic                  cmd_rd, cmd_rd_d, prog_en, prog_en_d;
  logic                  prog_cmd, prog_cmd_d, erase_pend, erase_pend_d;
  logic                  wip, wip_d, wel, wel_d;
  logic [ECW-1:0]        ecnt, ecnt_d;
  logic [7:0]            dq, dq_d;
  logic                  oe, oe_d;
  logic                  wr_en, erase_done;
  logic [7:0]            op;
  logic                  addr_last, dummy_last;

  assign op         = bus.ospi_dq_in;
  assign addr_inc   = addr + 1'b1;
  // program pointer wraps inside the page; upper address bits stay put
  assign addr_pg    = (addr & ~PMASK) | (addr_inc & PMASK);
  assign addr_last  = (cnt == 8'(ADDR_BYTES - 1));
  assign dummy_last = (cnt == 8'(DUMMY_CYCLES - 1));

`ifdef OSPI_RDID_EN
  function automatic logic [7:0] id_byte(input logic [7:0] i);
    case (i)
      8'd0:    id_byte = 8'hC2;
      8'd1:    id_byte = 8'h80;
      8'd2:    id_byte = 8'(ADDR_WIDTH);
      default: id_byte = 8'h00;
    endcase
  endfunction
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;

  always_comb begin
    state_d = state;
    if (bus.ospi_cs_n) state_d = S_IDLE;
    else if (bus.ospi_beat) begin
      case (state)
        S_IDLE: begin
          if (wip) state_d = (op == OP_RDSR) ? S_STAT : S_IGNORE;
          else begin
            case (op)
              OP_RDSR:          state_d = S_STAT;
              OP_READ, OP_PROG: state_d = S_ADDR;
`ifdef OSPI_RDID_EN
              OP_RDID:          state_d = S_ID;
`endif
              default:          state_d = S_IGNORE;
            endcase
          end
        end
        S_ADDR:  if (addr_last)
                   state_d = !cmd_rd ? S_WR : (DUMMY_CYCLES == 0) ? S_RD : S_DUMMY;
        S_DUMMY: if (dummy_last) state_d = S_RD;
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d        = cnt;
    addr_d       = addr;
    cmd_rd_d     = cmd_rd;
    prog_en_d    = prog_en;
    prog_cmd_d   = prog_cmd;
    erase_pend_d = erase_pend;
    wip_d        = wip;
    wel_d        = wel;
    ecnt_d       = ecnt;
    dq_d         = dq;
    wr_en        = 1'b0;
    erase_done   = 1'b0;
    // erase timer runs independently of bus activity
    if (wip) begin
      if (ecnt == ECW'(ERASE_CYCLES - 1)) begin
        erase_done = 1'b1;
        wip_d      = 1'b0;
        wel_d      = 1'b0;
        ecnt_d     = '0;
      end else ecnt_d = ecnt + 1'b1;
    end
    if (bus.ospi_cs_n) begin
      if (erase_pend) begin
        wip_d  = 1'b1;
        ecnt_d = '0;
      end
      if (prog_cmd) wel_d = 1'b0;
      erase_pend_d = 1'b0;
      prog_cmd_d   = 1'b0;
      prog_en_d    = 1'b0;
      cnt_d        = '0;
    end else if (bus.ospi_beat) begin
      case (state)
        S_IDLE: begin
          cnt_d = '0;
          if (!wip) begin
            case (op)
              OP_WREN:  wel_d = 1'b1;
              OP_WRDI:  wel_d = 1'b0;
              OP_ERASE: erase_pend_d = wel;
              OP_READ:  cmd_rd_d = 1'b1;
              OP_PROG: begin
                cmd_rd_d   = 1'b0;
                prog_cmd_d = 1'b1;
                prog_en_d  = wel;
              end
              default: ;
            endcase
          end
        end
        S_ADDR: begin
          // MSB first; bits shifted past ADDR_WIDTH simply fall off
          addr_d = ADDR_WIDTH'({addr, bus.ospi_dq_in});
          cnt_d  = addr_last ? 8'd0 : cnt + 1'b1;
        end
        S_DUMMY: cnt_d = cnt + 1'b1;
        S_RD:    addr_d = addr_inc;
        S_WR: begin
          wr_en  = prog_en;
          addr_d = addr_pg;
        end
        S_ID:    if (cnt != 8'd3) cnt_d = cnt + 1'b1;
        default: ;
      endcase
    end
    // dq always holds what the host will sample on the next beat
    if (state_d == S_STAT)    dq_d = {6'd0, wel_d, wip_d};
    else if (state_d == S_RD) dq_d = mem[addr_d];
`ifdef OSPI_RDID_EN
    else if (state_d == S_ID) dq_d = id_byte(cnt_d);
`endif
    oe_d = state_d inside {S_RD, S_STAT, S_ID};
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt        <= '0;
      addr       <= '0;
      cmd_rd     <= 1'b0;
      prog_en    <= 1'b0;
      prog_cmd   <= 1'b0;
      erase_pend <= 1'b0;
      wip        <= 1'b0;
      wel        <= 1'b0;
      ecnt       <= '0;
      dq         <= 8'h00;
      oe         <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      addr       <= addr_d;
      cmd_rd     <= cmd_rd_d;
      prog_en    <= prog_en_d;
      prog_cmd   <= prog_cmd_d;
      erase_pend <= erase_pend_d;
      wip        <= wip_d;
      wel        <= wel_d;
      ecnt       <= ecnt_d;
      dq         <= dq_d;
      oe         <= oe_d;
    end

  // array is never reset; flash program can only clear bits
  always_ff @(posedge clk) begin
    if (erase_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
    end else if (wr_en) mem[addr] <= mem[addr] & bus.ospi_dq_in;
  end

  assign bus.ospi_dq_out = dq;
  assign bus.ospi_dq_oe  = oe;
  assign bus.busy        = wip;
endmodule

// File: tb/tb_ospi_flash_target.sv
// Randomized bench for ospi_flash_target against a transaction-level flash model.
module tb_ospi_flash_target;
  localparam int AW = 8, DEPTH = 256, NDUMMY = 4, PS = 16, ERASE = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  ospi_flash_target_if bus();

  ospi_flash_target #(.ADDR_WIDTH(AW), .DUMMY_CYCLES(NDUMMY), .PAGE_SIZE(PS),
                      .ERASE_CYCLES(ERASE)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int         n_tests = 0, n_fail = 0;
  logic [7:0] mem_m [DEPTH];
  logic       wel_m;
  logic [7:0] wr_buf [64];
  logic [7:0] rd_buf [512];
  logic       rd_oe  [512];
  logic [7:0] q;
  logic       qoe;

  task automatic do_beat(input logic [7:0] d, output logic [7:0] qv, output logic oev);
    repeat ($urandom_range(0, 1)) @(posedge clk);
    @(negedge clk);
    bus.ospi_cs_n = 1'b0; bus.ospi_beat = 1'b1; bus.ospi_dq_in = d;
    #1; qv = bus.ospi_dq_out; oev = bus.ospi_dq_oe;
    @(posedge clk); #1; bus.ospi_beat = 1'b0;
  endtask

  task automatic cs_end();
    @(negedge clk); bus.ospi_cs_n = 1'b1; bus.ospi_beat = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cmd(input logic [7:0] op);
    do_beat(op, q, qoe); cs_end();
  endtask

  task automatic prog_txn(input logic [7:0] base, input int n);
    do_beat(8'h02, q, qoe); do_beat(base, q, qoe);
    for (int i = 0; i < n; i++) do_beat(wr_buf[i], q, qoe);
    cs_end();
  endtask

  task automatic read_txn(input logic [7:0] base, input int n);
    do_beat(8'h0B, q, qoe); do_beat(base, q, qoe);
    repeat (NDUMMY) do_beat(8'h00, q, qoe);
    for (int i = 0; i < n; i++) do_beat(8'h00, rd_buf[i], rd_oe[i]);
    cs_end();
  endtask

  task automatic rdsr_txn(output logic [7:0] s);
    do_beat(8'h05, q, qoe); do_beat(8'h00, s, qoe); cs_end();
  endtask

  // flash rules: program ANDs into a page-wrapped window only with WEL; WEL then clears
  function automatic void model_program(input logic [7:0] base, input int n);
    if (wel_m)
      for (int i = 0; i < n; i++) begin
        int a;
        a = (int'(base) / PS) * PS + (int'(base) + i) % PS;
        mem_m[a] = mem_m[a] & wr_buf[i];
      end
    wel_m = 1'b0;
  endfunction

  task automatic test_reset();
    bus.ospi_cs_n = 1'b1; bus.ospi_beat = 1'b0; bus.ospi_dq_in = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_tests++; if (bus.ospi_dq_out !== 8'h00) begin n_fail++; $display("FAIL reset_dq: got %h exp 00", bus.ospi_dq_out); end
    n_tests++; if (bus.ospi_dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b exp 0", bus.ospi_dq_oe); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    @(negedge clk); reset_n = 1'b1; wel_m = 1'b0;
    do_beat(8'h05, q, qoe); do_beat(8'h00, q, qoe);
    n_tests++; if (q !== 8'h00) begin n_fail++; $display("FAIL rdsr_after_reset: got %h exp 00", q); end
    n_tests++; if (qoe !== 1'b1) begin n_fail++; $display("FAIL rdsr_oe: got %b exp 1", qoe); end
    cs_end();
    n_tests++; if (bus.ospi_dq_oe !== 1'b0) begin n_fail++; $display("FAIL cs_high_oe: got %b exp 0", bus.ospi_dq_oe); end
  endtask

  task automatic test_rdid();
    logic [7:0] exp_id [4];
    exp_id[0] = 8'hC2; exp_id[1] = 8'h80; exp_id[2] = 8'(AW); exp_id[3] = 8'h00;
    do_beat(8'h9F, q, qoe);
    for (int i = 0; i < 4; i++) do_beat(8'h00, rd_buf[i], rd_oe[i]);
    cs_end();
    for (int i = 0; i < 4; i++) begin
`ifdef OSPI_RDID_EN
      n_tests++; if (rd_oe[i] !== 1'b1 || rd_buf[i] !== exp_id[i]) begin
        n_fail++; $display("FAIL rdid[%0d]: got %h oe=%b exp %h oe=1", i, rd_buf[i], rd_oe[i], exp_id[i]); end
`else
      n_tests++; if (rd_oe[i] !== 1'b0) begin
        n_fail++; $display("FAIL rdid_disabled_oe[%0d]: got %b exp 0 (id %h unused)", i, rd_oe[i], exp_id[i]); end
`endif
    end
  endtask

  task automatic test_erase();
    int n;
    logic [7:0] s;
    cmd(8'h06); wel_m = 1'b1;
    rdsr_txn(s);
    n_tests++; if (s !== 8'h02) begin n_fail++; $display("FAIL rdsr_wel: got %h exp 02", s); end
    do_beat(8'h60, q, qoe); cs_end();
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin n++; @(posedge clk); #1; end
    n_tests++; if (n != ERASE) begin n_fail++; $display("FAIL erase_busy_len: got %0d exp %0d", n, ERASE); end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
    wel_m = 1'b0;
    rdsr_txn(s);
    n_tests++; if (s !== 8'h00) begin n_fail++; $display("FAIL rdsr_post_erase: got %h exp 00", s); end
    read_txn(8'h00, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++; if (rd_buf[i] !== 8'hFF || rd_oe[i] !== 1'b1) begin
        n_fail++; $display("FAIL erase_read[%0d]: got %h oe=%b exp ff oe=1", i, rd_buf[i], rd_oe[i]); end
    end
  endtask

  task automatic test_page_program();
    logic [7:0] s;
    cmd(8'h06); wel_m = 1'b1;
    wr_buf[0] = 8'hA5; wr_buf[1] = 8'h5A; wr_buf[2] = 8'h3C;
    prog_txn(8'h0E, 3); model_program(8'h0E, 3);
    read_txn(8'h00, 16);
    n_tests++; if (rd_buf[14] !== 8'hA5) begin n_fail++; $display("FAIL pp_0e: got %h exp a5", rd_buf[14]); end
    n_tests++; if (rd_buf[15] !== 8'h5A) begin n_fail++; $display("FAIL pp_0f: got %h exp 5a", rd_buf[15]); end
    n_tests++; if (rd_buf[0] !== 8'h3C) begin n_fail++; $display("FAIL pp_wrap_00: got %h exp 3c", rd_buf[0]); end
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (rd_buf[i] !== mem_m[i]) begin
        n_fail++; $display("FAIL pp_read[%0d]: got %h exp %h", i, rd_buf[i], mem_m[i]); end
    end
    rdsr_txn(s);
    n_tests++; if (s !== 8'h00) begin n_fail++; $display("FAIL pp_wel_clear: got %h exp 00", s); end
  endtask

  task automatic test_no_wren();
    logic [7:0] s;
    wr_buf[0] = 8'h00;
    prog_txn(8'h10, 1); model_program(8'h10, 1);
    read_txn(8'h10, 1);
    n_tests++; if (rd_buf[0] !== 8'hFF || rd_buf[0] !== mem_m[16]) begin
      n_fail++; $display("FAIL no_wren_mem: got %h exp ff", rd_buf[0]); end
    rdsr_txn(s);
    n_tests++; if (s !== 8'h00) begin n_fail++; $display("FAIL no_wren_rdsr: got %h exp 00", s); end
  endtask

  task automatic test_and_semantics();
    cmd(8'h06); wel_m = 1'b1; wr_buf[0] = 8'hF0; prog_txn(8'h40, 1); model_program(8'h40, 1);
    cmd(8'h06); wel_m = 1'b1; wr_buf[0] = 8'h3F; prog_txn(8'h40, 1); model_program(8'h40, 1);
    read_txn(8'h40, 1);
    n_tests++; if (rd_buf[0] !== 8'h30) begin n_fail++; $display("FAIL and_prog: got %h exp 30", rd_buf[0]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int kind, len;
      logic [7:0] base;
      kind = $urandom_range(0, 3);
      if (kind < 3) begin
        if (kind < 2) begin cmd(8'h06); wel_m = 1'b1; end
        base = 8'($urandom);
        len  = $urandom_range(1, 20);
        for (int i = 0; i < len; i++) wr_buf[i] = 8'($urandom);
        prog_txn(base, len); model_program(base, len);
      end
      base = 8'($urandom);
      len  = $urandom_range(1, 40);
      read_txn(base, len);
      for (int i = 0; i < len; i++) begin
        n_tests++; if (rd_buf[i] !== mem_m[(int'(base) + i) % DEPTH] || rd_oe[i] !== 1'b1) begin
          n_fail++; $display("FAIL rand_read it%0d addr %h: got %h oe=%b exp %h",
                             it, 8'(int'(base) + i), rd_buf[i], rd_oe[i], mem_m[(int'(base) + i) % DEPTH]); end
      end
    end
  endtask

  task automatic test_erase_busy();
    int n;
    logic bad;
    cmd(8'h06); wel_m = 1'b1;
    do_beat(8'h60, q, qoe); cs_end();
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL eb_busy: got %b exp 1", bus.busy); end
    do_beat(8'h0B, q, qoe); do_beat(8'h00, q, qoe);
    repeat (NDUMMY) do_beat(8'h00, q, qoe);
    for (int i = 0; i < 2; i++) begin
      do_beat(8'h00, q, qoe);
      n_tests++; if (qoe !== 1'b0) begin n_fail++; $display("FAIL eb_read_oe[%0d]: got %b exp 0", i, qoe); end
    end
    cs_end();
    do_beat(8'h05, q, qoe); do_beat(8'h00, q, qoe);
    n_tests++; if (q !== 8'h03) begin n_fail++; $display("FAIL eb_rdsr_first: got %h exp 03", q); end
    n = 0; bad = 1'b0;
    while (q !== 8'h00 && n < 100) begin
      do_beat(8'h00, q, qoe); n++;
      if (q !== 8'h03 && q !== 8'h00) bad = 1'b1;
    end
    cs_end();
    n_tests++; if (q !== 8'h00) begin n_fail++; $display("FAIL eb_rdsr_timeout: got %h exp 00", q); end
    n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL eb_rdsr_values: got stray %b exp 0", bad); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL eb_busy_end: got %b exp 0", bus.busy); end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
    wel_m = 1'b0;
    read_txn(8'h00, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++; if (rd_buf[i] !== 8'hFF) begin n_fail++; $display("FAIL eb_read[%0d]: got %h exp ff", i, rd_buf[i]); end
    end
  endtask

  task automatic test_erase_reset();
    logic [7:0] base, s;
    cmd(8'h06); wel_m = 1'b1;
    base = 8'($urandom);
    for (int i = 0; i < 8; i++) wr_buf[i] = 8'($urandom_range(0, 254));
    prog_txn(base, 8); model_program(base, 8);
    cmd(8'h06); wel_m = 1'b1;
    do_beat(8'h60, q, qoe); cs_end();
    repeat (9) @(posedge clk); #1;
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL er_busy_pre: got %b exp 1", bus.busy); end
    reset_n = 1'b0; #2;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL er_busy_reset: got %b exp 0", bus.busy); end
    @(negedge clk); reset_n = 1'b1; wel_m = 1'b0;
    repeat (ERASE + 5) @(posedge clk); #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL er_busy_post: got %b exp 0", bus.busy); end
    rdsr_txn(s);
    n_tests++; if (s !== 8'h00) begin n_fail++; $display("FAIL er_rdsr: got %h exp 00", s); end
    read_txn(8'h00, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++; if (rd_buf[i] !== mem_m[i]) begin
        n_fail++; $display("FAIL er_mem[%0d]: got %h exp %h", i, rd_buf[i], mem_m[i]); end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: sim time %0t exceeded bound", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rdid();
    test_erase();
    test_page_program();
    test_no_wren();
    test_and_semantics();
    test_random();
    test_erase_busy();
    test_erase_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
